// File: rtl/obstacle_renderer.sv
// Multi-slot obstacle engine: spawn/scroll slot state plus a 2-cycle sprite ROM pixel pipeline.
// Lowest-index slot wins both spawn allocation and pixel priority.
module obstacle_renderer #(
  parameter int unsigned SLOTS    = 3,
  parameter int unsigned GROUND   = 150,
  parameter int unsigned SCREEN_W = 320,
  parameter int unsigned W0       = 26,
  parameter int unsigned H0       = 40,
  parameter int unsigned W1       = 34,
  parameter int unsigned H1       = 24,
  parameter logic [11:0] KEY      = 12'hFFF,
  parameter int unsigned ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              frame_tick,
  input  logic [3:0]        speed,
  input  logic              spawn_valid,
  input  logic              spawn_type,
  output logic              spawn_ready,
  output logic [SLOTS-1:0]  active_mask,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic              obstacle_px,
  output logic [3:0]        vgaRed,
  output logic [3:0]        vgaGreen,
  output logic [3:0]        vgaBlue
);

  localparam logic [9:0]        W0_P     = 10'(W0);
  localparam logic [9:0]        W1_P     = 10'(W1);
  localparam logic [9:0]        H0_P     = 10'(H0);
  localparam logic [9:0]        H1_P     = 10'(H1);
  localparam logic [9:0]        GROUND_P = 10'(GROUND);
  localparam logic [9:0]        SCREEN_P = 10'(SCREEN_W);
  localparam logic [ADDR_W-1:0] BASE1    = ADDR_W'(W0 * H0);

  logic [SLOTS-1:0] active_q;
  logic [SLOTS-1:0] type_q;
  logic [9:0]       pos_q [SLOTS];

  logic [SLOTS-1:0] spawn_sel;
  logic             spawn_found;
  logic [9:0]       spawn_pos;
  logic             spawn_fire;

  logic [9:0]        h_addr;
  logic [9:0]        v_addr;
  logic [SLOTS-1:0]  slot_hit;
  logic [ADDR_W-1:0] slot_addr [SLOTS];
  logic              hit_any;
  logic [ADDR_W-1:0] sel_addr;

  logic              hit_q;
  logic              hit_d_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              px_q;
  logic              px_d;
  logic [11:0]       rgb_q;
  logic              unused_lsb;

  assign unused_lsb  = h_cnt[0] ^ v_cnt[0];
  assign h_addr      = {1'b0, h_cnt[9:1]};
  assign v_addr      = {1'b0, v_cnt[9:1]};
  assign spawn_ready = ~&active_q;
  assign active_mask = active_q;
  assign spawn_pos   = spawn_type ? (SCREEN_P + W1_P) : (SCREEN_P + W0_P);
  assign spawn_fire  = spawn_valid && spawn_ready;

  always_comb begin
    spawn_sel   = '0;
    spawn_found = 1'b0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (!active_q[i] && !spawn_found) begin
        spawn_sel[i] = 1'b1;
        spawn_found  = 1'b1;
      end
    end
  end

  // A slot freed by this tick is still marked active here, so it cannot be reallocated on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= '0;
      type_q   <= '0;
      for (int unsigned i = 0; i < SLOTS; i++) pos_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        if (spawn_fire && spawn_sel[i]) begin
          active_q[i] <= 1'b1;
          type_q[i]   <= spawn_type;
          pos_q[i]    <= spawn_pos;
        end else if (frame_tick && active_q[i]) begin
          if (pos_q[i] > {6'd0, speed}) begin
            pos_q[i] <= pos_q[i] - {6'd0, speed};
          end else begin
            active_q[i] <= 1'b0;
            pos_q[i]    <= '0;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    logic [9:0]        w;
    logic [9:0]        top;
    logic [9:0]        x0;
    logic [9:0]        right;
    logic [ADDR_W-1:0] base;
    assign w     = type_q[g] ? W1_P : W0_P;
    assign top   = GROUND_P - (type_q[g] ? H1_P : H0_P);
    assign x0    = (pos_q[g] >= w) ? (pos_q[g] - w) : '0;
    assign right = (pos_q[g] < SCREEN_P) ? pos_q[g] : SCREEN_P;
    assign base  = type_q[g] ? BASE1 : '0;
    assign slot_hit[g] = active_q[g] && (h_addr >= x0) && (h_addr < right) &&
                         (v_addr >= top) && (v_addr < GROUND_P);
    // Column is taken from the unclipped left edge: h - (pos - w) == h + w - pos, non-negative on a hit.
    assign slot_addr[g] = base + ADDR_W'(v_addr - top) * ADDR_W'(w) +
                          (ADDR_W'(h_addr) + ADDR_W'(w) - ADDR_W'(pos_q[g]));
  end

  always_comb begin
    hit_any  = 1'b0;
    sel_addr = rom_addr_q;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (slot_hit[i] && !hit_any) begin
        hit_any  = 1'b1;
        sel_addr = slot_addr[i];
      end
    end
  end

  assign px_d = hit_d_q && (rom_data != KEY);

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_q <= '0;
      hit_q      <= 1'b0;
      hit_d_q    <= 1'b0;
      px_q       <= 1'b0;
      rgb_q      <= 12'hFFF;
    end else begin
      rom_addr_q <= sel_addr;
      hit_q      <= hit_any;
      hit_d_q    <= hit_q;
      px_q       <= px_d;
      rgb_q      <= px_d ? rom_data : 12'hFFF;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign obstacle_px = px_q;
  assign vgaRed      = rgb_q[11:8];
  assign vgaGreen    = rgb_q[7:4];
  assign vgaBlue     = rgb_q[3:0];

endmodule

// File: doc/obstacle_renderer.md
# obstacle_renderer

Multi-slot obstacle engine for the dino game's 320×240 half-resolution playfield. It holds up to SLOTS concurrent obstacles, each of one of two sprite types, and accepts new obstacles through a valid/ready spawn port. Every frame it scrolls all active obstacles left by a programmable speed. It fetches sprite pixels from one shared synchronous sprite ROM through a registered 2-cycle pixel pipeline, and sits between the VGA timing counters and the top-level pixel compositor.

## Interface
- SLOTS, 3, number of concurrent obstacle slots (1–8)
- GROUND, 150, half-res y of the row just below every obstacle's bottom edge
- SCREEN_W, 320, half-res playfield width
- W0, 26, width of type-0 sprite in pixels
- H0, 40, height of type-0 sprite in pixels
- W1, 34, width of type-1 sprite in pixels
- H1, 24, height of type-1 sprite in pixels
- KEY, 12'hFFF, transparent colour key
- ADDR_W, 17, ROM address width

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- h_cnt  in  10  VGA horizontal counter in full resolution
- v_cnt  in  10  VGA vertical counter in full resolution
- frame_tick  in  1  one-cycle pulse, issued once per frame during vertical blanking
- speed  in  4  scroll step in half-res pixels per frame
- spawn_valid  in  1  request to spawn an obstacle
- spawn_type  in  1  sprite type of the requested obstacle
- spawn_ready  out  1  a slot is free
- active_mask  out  SLOTS  bit i is set when slot i is occupied
- rom_addr  out  ADDR_W  address to the sprite ROM
- rom_data  in  12  ROM data; valid one cycle after rom_addr
- obstacle_px  out  1  the current output pixel is an opaque obstacle pixel
- vgaRed, vgaGreen, vgaBlue  out  4 each  output colour

## Operation
- **Slot state.** Each slot holds `active`, `type`, and `pos`.
  - `pos` is 10 bits and is the exclusive right edge in half-res x.
  - The sprite occupies x in [pos−W, pos) and y in [GROUND−H, GROUND). W and H are those of the slot's type.
- **Spawn.**
  - spawn_ready = OR of the inactive bits, taken from registered state.
  - On spawn_valid && spawn_ready, the lowest-index free slot takes active=1, type=spawn_type, pos=SCREEN_W+W(type). The obstacle enters fully off-screen on the right.
  - spawn_valid while spawn_ready=0 is ignored. The request is neither queued nor dropped with a flag.
- **Scroll.** On frame_tick, each active slot with pos > speed takes pos ← pos − speed.
  - An active slot with pos ≤ speed goes inactive, and its pos is cleared to 0.
  - speed=0 leaves all positions unchanged.
- **Simultaneous events.**
  - A slot spawned on the same edge as frame_tick is not decremented on that edge.
  - A slot freed by frame_tick becomes available for spawns from the next cycle on.
- **Hit test (stage 0).**
  - Compute h_addr = h_cnt>>1 and v_addr = v_cnt>>1.
  - The left edge x0 = pos−W, saturated at 0.
  - Slot i hits when it is active, x0 ≤ h_addr < min(pos, SCREEN_W), and GROUND−H ≤ v_addr < GROUND.
  - When several slots hit, the lowest index wins.
- **Address.**
  - rom_addr = base(type) + (v_addr−(GROUND−H))·W + (h_addr−(pos−W)).
  - base(0) = 0; base(1) = W0·H0.
  - The column offset uses the unclipped left edge, so a sprite partly off the left side shows its right part.
  - rom_addr and a hit flag are registered at the end of stage 0.
  - With no hit, rom_addr holds its previous value.
- **Output (stage 2).**
  - obstacle_px = hit_d && rom_data ≠ KEY.
  - RGB = rom_data when obstacle_px is set, otherwise 12'hFFF.
  - Both RGB and obstacle_px are registered.

## Timing
- **Reset values:**
  - all slots inactive, pos = 0
  - active_mask = 0
  - spawn_ready = 1
  - rom_addr = 0
  - pipeline hit flags = 0
  - obstacle_px = 0
  - RGB = 12'hFFF
- **Latency.**
  - h_cnt/v_cnt sampled at edge n produce rom_addr at edge n.
  - rom_data is available during cycle n+1.
  - RGB/obstacle_px are updated at edge n+2, i.e. 2 cycles of latency. Upstream delays hsync/vsync to match.
- **Slot updates.** Slot state changes only on spawn acceptance or frame_tick, never on any other cycle.
- **Reset mid-frame.** Reset clears all slots and the pipeline in one edge. The next output is 12'hFFF.
- **Width rules.**
  - Position arithmetic is 10-bit unsigned. SCREEN_W+max(W0,W1) must be < 1024.
  - The address product is ADDR_W wide; no truncation is allowed for the default parameters.

## Test plan
- **Reset:** assert rst for 2 cycles with spawn_valid=1 → after reset, active_mask=0, spawn_ready=1, RGB=FFF, obstacle_px=0.
- **Spawn and fill:**
  - spawn type 0, then type 1, then type 0 on consecutive cycles → active_mask = 001, 011, 111; slot pos = 346, 354, 346.
  - spawn_ready=0 afterwards; a fourth spawn_valid leaves state unchanged.
- **Scroll and expiry:**
  - slot 0 of type 0 at pos=346, speed=5, 69 frame_ticks → pos=1.
  - The next tick frees slot 0 (active_mask bit 0 = 0, spawn_ready=1).
- **Simultaneous events:**
  - frame_tick together with a spawn into a free slot → the new slot's pos is SCREEN_W+W with no decrement.
  - A slot freed on that same tick is not chosen on that edge.
- **Pixel path:**
  - type-0 slot at pos=100; drive h_cnt=150, v_cnt=222 (h=75, v=111) → rom_addr = 1·26+1 = 27 one edge later.
  - With rom_data=12'h0A0, RGB=0A0 and obstacle_px=1 two edges after the counts.
  - With rom_data=KEY, RGB=FFF and obstacle_px=0.
- **Priority and clipping:**
  - overlapping slots 0 and 2 → slot 0's address is used.
  - A type-1 slot at pos=10 with h_addr=0, v_addr=GROUND−H1 → rom_addr = base(1)+24 = 1064.
